pong_game_ctrl: RTL and testbench

//  Consumes the MCU control bits (mcu_btn, mcu_sw, mcu_str, mcu_img) from the AHB register slave.

---
 rtl/pong_pkg.sv | 30 +++
 rtl/pong_game_ctrl_if.sv | 27 ++
 rtl/sync_edge.sv | 47 ++++
 rtl/pong_game_ctrl.sv | 111 +++++++++++
 tb/tb_pong_game_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: state encoding,
// paddle length table and default screen geometry.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_MENU  = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  localparam logic [7:0] LEN_00 = 8'd32;
  localparam logic [7:0] LEN_01 = 8'd48;
  localparam logic [7:0] LEN_10 = 8'd64;
  localparam logic [7:0] LEN_11 = 8'd96;

  localparam int SCREEN_W_DEF = 1280;
  localparam int POS_W_DEF    = 11;
  localparam int PAD_STEP_DEF = 8;

  function automatic logic [7:0] len_lut(input logic [1:0] sw);
    case (sw)
      2'b00:   len_lut = LEN_00;
      2'b01:   len_lut = LEN_01;
      2'b10:   len_lut = LEN_10;
      default: len_lut = LEN_11;
    endcase
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// MCU control inputs and game/paddle outputs of the pong controller.
// The slave modport is the controller; the master modport drives it.
interface pong_game_ctrl_if #(
  parameter int POS_W = 11
);
  logic [1:0]       mcu_btn;
  logic [1:0]       mcu_sw;
  logic             mcu_str;
  logic             mcu_img;
  logic             frame_tick;
  logic [1:0]       game_state;
  logic             show_menu;
  logic             run_en;
  logic             rst_game;
  logic [POS_W-1:0] paddle_x;
  logic [7:0]       paddle_len;

  modport master (
    output mcu_btn, mcu_sw, mcu_str, mcu_img, frame_tick,
    input  game_state, show_menu, run_en, rst_game, paddle_x, paddle_len
  );

  modport slave (
    input  mcu_btn, mcu_sw, mcu_str, mcu_img, frame_tick,
    output game_state, show_menu, run_en, rst_game, paddle_x, paddle_len
  );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer with optional registered rising-edge pulse.
// Reset value is a parameter so inputs held high across reset give no edge.
module sync_edge #(
  parameter int   W       = 1,
  parameter logic RST_VAL = 1'b0,
  parameter logic EDGE_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] lvl_o,
  output logic [W-1:0] rise_o
);
  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= {W{RST_VAL}};
      s2_q <= {W{RST_VAL}};
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign lvl_o = s2_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic [W-1:0] s2d_q, rise_q;
      // pulse is registered so a state update lands three edges after the first sample
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s2d_q  <= {W{RST_VAL}};
          rise_q <= '0;
        end else begin
          s2d_q  <= s2_q;
          rise_q <= s2_q & ~s2d_q;
        end
      end
      assign rise_o = rise_q;
    end else begin : g_no_edge
      assign rise_o = '0;
    end
  endgenerate

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: synchronizes MCU controls, runs the game FSM and
// computes paddle length and position on the pixel clock.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int POS_W    = POS_W_DEF,
  parameter int PAD_STEP = PAD_STEP_DEF
) (
  input logic             CLK,
  input logic             RST,
  pong_game_ctrl_if.slave bus
);
  localparam int               XW    = POS_W + 1;
  localparam logic [XW-1:0]    SCR_W = XW'(SCREEN_W);
  localparam logic [XW-1:0]    STEP  = XW'(PAD_STEP);
  localparam logic [POS_W-1:0] X_RST = POS_W'((SCREEN_W - int'(LEN_00)) / 2);

  logic [1:0] si_rise, si_lvl_unused;
  logic [3:0] bs_lvl, bs_rise_unused;
  logic       str_rise, img_rise;
  logic [1:0] btn, sw;

  sync_edge #(.W(2), .RST_VAL(1'b1), .EDGE_EN(1'b1)) u_sync_si (
    .clk_i  (CLK),
    .rst_i  (RST),
    .d_i    ({bus.mcu_img, bus.mcu_str}),
    .lvl_o  (si_lvl_unused),
    .rise_o (si_rise)
  );

  sync_edge #(.W(4), .RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_bs (
    .clk_i  (CLK),
    .rst_i  (RST),
    .d_i    ({bus.mcu_sw, bus.mcu_btn}),
    .lvl_o  (bs_lvl),
    .rise_o (bs_rise_unused)
  );

  assign str_rise = si_rise[0];
  assign img_rise = si_rise[1];
  assign btn      = bs_lvl[1:0];
  assign sw       = bs_lvl[3:2];

  state_e           state_q;
  logic             rst_game_q;
  logic [7:0]       len_q, len_d;
  logic [POS_W-1:0] x_q, x_d;
  logic             latch_len;
  logic [XW-1:0]    x_ext, len_ext, x_nx;

  // img_rise always wins over str_rise, so it is tested first in every state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_MENU;
      rst_game_q <= 1'b0;
    end else begin
      rst_game_q <= 1'b0;
      case (state_q)
        ST_MENU:  if (img_rise) begin
                    state_q    <= ST_READY;
                    rst_game_q <= 1'b1;
                  end
        ST_READY: if (img_rise) state_q <= ST_MENU;
                  else if (str_rise) state_q <= ST_RUN;
        ST_RUN:   if (img_rise) state_q <= ST_MENU;
                  else if (str_rise) state_q <= ST_PAUSE;
        default:  if (img_rise) state_q <= ST_MENU;
                  else if (str_rise) state_q <= ST_RUN;
      endcase
    end
  end

  // all geometry math is one bit wider than paddle_x so sums cannot wrap
  always_comb begin
    latch_len = (state_q == ST_MENU) || (state_q == ST_READY);
    len_d     = latch_len ? len_lut(sw) : len_q;
    x_ext     = XW'(x_q);
    len_ext   = XW'(len_d);
    x_nx      = x_ext;
    if (state_q == ST_MENU && img_rise) begin
      x_nx = (SCR_W - len_ext) >> 1;
    end else if (latch_len && (x_ext + len_ext > SCR_W)) begin
      x_nx = SCR_W - len_ext;
    end else if (state_q == ST_RUN && bus.frame_tick) begin
      if (btn == 2'b01)
        x_nx = (x_ext < STEP) ? '0 : x_ext - STEP;
      else if (btn == 2'b10)
        x_nx = (x_ext + len_ext + STEP > SCR_W) ? SCR_W - len_ext : x_ext + STEP;
    end
    x_d = x_nx[POS_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      len_q <= LEN_00;
      x_q   <= X_RST;
    end else begin
      len_q <= len_d;
      x_q   <= x_d;
    end
  end

  assign bus.game_state = state_q;
  assign bus.show_menu  = (state_q == ST_MENU);
  assign bus.run_en     = (state_q == ST_RUN);
  assign bus.rst_game   = rst_game_q;
  assign bus.paddle_x   = x_q;
  assign bus.paddle_len = len_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: FSM sequencing, sync latency,
// paddle saturation, length latching/clamp and mid-game reset.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pong_game_ctrl_if #(.POS_W(11)) bus ();

  pong_game_ctrl #(.SCREEN_W(1280), .POS_W(11), .PAD_STEP(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      cyc(1);
      bus.frame_tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic press_str();
    bus.mcu_str = 1'b1;
    cyc(4);
    bus.mcu_str = 1'b0;
    cyc(3);
  endtask

  task automatic press_img();
    bus.mcu_img = 1'b1;
    cyc(4);
    bus.mcu_img = 1'b0;
    cyc(3);
  endtask

  logic [10:0] prev_x;
  logic        wrapped;

  initial begin
    rst            = 1'b1;
    bus.mcu_btn    = 2'b00;
    bus.mcu_sw     = 2'b00;
    bus.mcu_str    = 1'b1;
    bus.mcu_img    = 1'b0;
    bus.frame_tick = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(6);

    // reset state with str held high
    chk("rst_state", 32'(bus.game_state), 32'd0);
    chk("rst_x", 32'(bus.paddle_x), 32'd624);
    chk("rst_len", 32'(bus.paddle_len), 32'd32);
    chk("rst_menu", 32'(bus.show_menu), 32'd1);
    chk("rst_run_en", 32'(bus.run_en), 32'd0);
    chk("rst_rst_game", 32'(bus.rst_game), 32'd0);
    bus.mcu_str = 1'b0;
    cyc(3);

    // img latency: first sampled at the next edge, update three edges later
    bus.mcu_img = 1'b1;
    cyc(3);
    chk("img_lat_early", 32'(bus.game_state), 32'd0);
    cyc(1);
    chk("img_ready", 32'(bus.game_state), 32'd1);
    chk("rst_game_hi", 32'(bus.rst_game), 32'd1);
    chk("ready_center", 32'(bus.paddle_x), 32'd624);
    cyc(1);
    chk("rst_game_lo", 32'(bus.rst_game), 32'd0);
    bus.mcu_img = 1'b0;
    cyc(3);

    bus.mcu_str = 1'b1;
    cyc(4);
    chk("str_run", 32'(bus.game_state), 32'd2);
    chk("run_en", 32'(bus.run_en), 32'd1);
    chk("run_menu_off", 32'(bus.show_menu), 32'd0);
    bus.mcu_str = 1'b0;
    cyc(3);

    // right saturation, then left to zero
    bus.mcu_btn = 2'b10;
    cyc(3);
    prev_x  = bus.paddle_x;
    wrapped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      frames(1);
      if (bus.paddle_x < prev_x) wrapped = 1'b1;
      prev_x = bus.paddle_x;
    end
    chk("right_sat", 32'(bus.paddle_x), 32'd1248);
    chk("right_nowrap", 32'(wrapped), 32'd0);
    bus.mcu_btn = 2'b01;
    cyc(3);
    frames(200);
    chk("left_zero", 32'(bus.paddle_x), 32'd0);

    // hold cases: btn=11 and PAUSE
    bus.mcu_btn = 2'b10;
    cyc(3);
    frames(5);
    chk("move_40", 32'(bus.paddle_x), 32'd40);
    bus.mcu_btn = 2'b11;
    cyc(3);
    frames(4);
    chk("btn11_hold", 32'(bus.paddle_x), 32'd40);
    press_str();
    chk("pause_state", 32'(bus.game_state), 32'd3);
    chk("pause_run_en", 32'(bus.run_en), 32'd0);
    bus.mcu_btn = 2'b10;
    cyc(3);
    frames(4);
    chk("pause_hold", 32'(bus.paddle_x), 32'd40);
    press_str();
    chk("resume_run", 32'(bus.game_state), 32'd2);
    bus.mcu_sw = 2'b11;
    cyc(5);
    chk("run_len_frozen", 32'(bus.paddle_len), 32'd32);

    // length change clamps paddle_x on the same edge (menu latches length)
    bus.mcu_sw = 2'b00;
    cyc(3);
    frames(160);
    chk("right_sat2", 32'(bus.paddle_x), 32'd1248);
    bus.mcu_btn = 2'b00;
    press_img();
    chk("back_menu", 32'(bus.game_state), 32'd0);
    chk("menu_x_kept", 32'(bus.paddle_x), 32'd1248);
    bus.mcu_sw = 2'b11;
    cyc(2);
    chk("len_before", 32'(bus.paddle_len), 32'd32);
    cyc(1);
    chk("len_96", 32'(bus.paddle_len), 32'd96);
    chk("clamp_1184", 32'(bus.paddle_x), 32'd1184);

    // img has priority over a simultaneous str in RUN
    press_img();
    chk("recenter_96", 32'(bus.paddle_x), 32'd592);
    press_str();
    chk("run_again", 32'(bus.game_state), 32'd2);
    bus.mcu_str = 1'b1;
    bus.mcu_img = 1'b1;
    cyc(4);
    chk("img_prio", 32'(bus.game_state), 32'd0);
    bus.mcu_str = 1'b0;
    bus.mcu_img = 1'b0;
    cyc(3);

    // mid-RUN reset with an img edge in flight
    press_img();
    press_str();
    chk("run_pre_rst", 32'(bus.game_state), 32'd2);
    bus.mcu_img = 1'b1;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_state", 32'(bus.game_state), 32'd0);
    chk("mid_rst_x", 32'(bus.paddle_x), 32'd624);
    chk("mid_rst_len", 32'(bus.paddle_len), 32'd32);
    chk("mid_rst_menu", 32'(bus.show_menu), 32'd1);
    chk("mid_rst_run_en", 32'(bus.run_en), 32'd0);
    chk("mid_rst_game", 32'(bus.rst_game), 32'd0);
    rst = 1'b0;
    cyc(6);
    chk("pending_dropped", 32'(bus.game_state), 32'd0);
    bus.mcu_img = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
